conversor_bcd_seq: RTL and testbench



---
 rtl/conversor_bcd_seq.sv | 146 ++++++++++++++
 tb/tb_conversor_bcd_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/conversor_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) for sign-magnitude operands.
// Optional 7-segment output with leading-zero blanking when CONVERSOR_SETE_SEG_EN is defined.
module conversor_bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [WIDTH-1:0]    valor,
    input  logic                sinal,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd,
    output logic                sinal_out,
    output logic                overflow
`ifdef CONVERSOR_SETE_SEG_EN
    ,
    output logic [7*DIGITS-1:0] seg
`endif
);

    localparam int SW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0] MAXV = pow10(DIGITS) - 64'd1;

    typedef enum logic [1:0] {IDLE, CONV, FIM} state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [SW-1:0]    scr_q, scr_d, scr_adj;
    logic [CW-1:0]    cnt_q;
    logic             sig_q, ovf_q;
    logic [SW-1:0]    bcd_q;
    logic             sinal_out_q, overflow_q;
    logic             accept, last;

    assign accept = (state_q == IDLE) && start;
    assign last   = (state_q == CONV) && (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CONV;
            CONV:    if (last)  state_d = FIM;
            FIM:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Add-3 on all digits in parallel, then shift the {scratch, binary} pair;
    // the bit leaving the top digit is dropped, giving valor mod 10^DIGITS.
    always_comb begin
        scr_adj = scr_q;
        for (int i = 0; i < DIGITS; i++)
            if (scr_q[4*i +: 4] >= 4'd5) scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
        scr_d = {scr_adj[SW-2:0], bin_q[WIDTH-1]};
        bin_d = {bin_q[WIDTH-2:0], 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q       <= '0;
            scr_q       <= '0;
            cnt_q       <= '0;
            sig_q       <= 1'b0;
            ovf_q       <= 1'b0;
            bcd_q       <= '0;
            sinal_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else if (accept) begin
            bin_q <= valor;
            scr_q <= '0;
            cnt_q <= '0;
            sig_q <= sinal && (valor != '0);
            ovf_q <= 64'(valor) > MAXV;
        end else if (state_q == CONV) begin
            bin_q <= bin_d;
            scr_q <= scr_d;
            cnt_q <= cnt_q + CW'(1);
            if (last) begin
                bcd_q       <= scr_d;
                sinal_out_q <= sig_q;
                overflow_q  <= ovf_q;
            end
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIM);
    assign bcd       = bcd_q;
    assign sinal_out = sinal_out_q;
    assign overflow  = overflow_q;

`ifdef CONVERSOR_SETE_SEG_EN
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b0111111;
            4'd1:    seg7 = 7'b0000110;
            4'd2:    seg7 = 7'b1011011;
            4'd3:    seg7 = 7'b1001111;
            4'd4:    seg7 = 7'b1100110;
            4'd5:    seg7 = 7'b1101101;
            4'd6:    seg7 = 7'b1111101;
            4'd7:    seg7 = 7'b0000111;
            4'd8:    seg7 = 7'b1111111;
            4'd9:    seg7 = 7'b1101111;
            default: seg7 = 7'b0000000;
        endcase
    endfunction

    logic [7*DIGITS-1:0] seg_q, seg_d;
    logic                lit;

    // Walk from the top digit down; a digit lights once a nonzero digit (or units) is reached.
    always_comb begin
        seg_d = '0;
        lit   = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (scr_d[4*i +: 4] != 4'd0 || i == 0) lit = 1'b1;
            if (lit) seg_d[7*i +: 7] = seg7(scr_d[4*i +: 4]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    seg_q <= '0;
        else if (last) seg_q <= seg_d;
    end

    assign seg = seg_q;
`endif

endmodule

// File: tb/tb_conversor_bcd_seq.sv
// Directed bench for conversor_bcd_seq: three instances (8/3, 8/2, 16/5) share clock, reset and operand.
module tb_conversor_bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, start_b, start_c;
    logic [15:0] valor;
    logic        sinal;

    logic        busy_a, done_a, sgn_a, ovf_a;
    logic        busy_b, done_b, sgn_b, ovf_b;
    logic        busy_c, done_c, sgn_c, ovf_c;
    logic [11:0] bcd_a;
    logic [7:0]  bcd_b;
    logic [19:0] bcd_c;
`ifdef CONVERSOR_SETE_SEG_EN
    logic [20:0] seg_a;
    logic [13:0] seg_b;
    logic [34:0] seg_c;
`endif

    always #5 clk = ~clk;

    conversor_bcd_seq #(.WIDTH(8), .DIGITS(3)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .valor(valor[7:0]), .sinal(sinal),
        .busy(busy_a), .done(done_a), .bcd(bcd_a), .sinal_out(sgn_a), .overflow(ovf_a)
`ifdef CONVERSOR_SETE_SEG_EN
        , .seg(seg_a)
`endif
    );

    conversor_bcd_seq #(.WIDTH(8), .DIGITS(2)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .valor(valor[7:0]), .sinal(sinal),
        .busy(busy_b), .done(done_b), .bcd(bcd_b), .sinal_out(sgn_b), .overflow(ovf_b)
`ifdef CONVERSOR_SETE_SEG_EN
        , .seg(seg_b)
`endif
    );

    conversor_bcd_seq #(.WIDTH(16), .DIGITS(5)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .valor(valor), .sinal(sinal),
        .busy(busy_c), .done(done_c), .bcd(bcd_c), .sinal_out(sgn_c), .overflow(ovf_c)
`ifdef CONVERSOR_SETE_SEG_EN
        , .seg(seg_c)
`endif
    );

    int tests = 0;
    int fails = 0;
    int sel   = 0;
    int lat, busyc, dones;
    logic [19:0] mid;

    logic        busy_s, done_s, sgn_s, ovf_s;
    logic [19:0] bcd_s;

    always_comb begin
        busy_s = busy_a; done_s = done_a; sgn_s = sgn_a; ovf_s = ovf_a; bcd_s = {8'h0, bcd_a};
        case (sel)
            1: begin busy_s = busy_b; done_s = done_b; sgn_s = sgn_b; ovf_s = ovf_b; bcd_s = {12'h0, bcd_b}; end
            2: begin busy_s = busy_c; done_s = done_c; sgn_s = sgn_c; ovf_s = ovf_c; bcd_s = bcd_c; end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic set_start(input int which, input logic v);
        case (which)
            0: start_a = v;
            1: start_b = v;
            default: start_c = v;
        endcase
    endtask

    // One start pulse (or start held through CONV when hold=1); observes 40 cycles.
    // lat = index of the first cycle after the start edge in which done is high.
    task automatic conv(input int which, input logic [15:0] v, input logic s, input bit hold);
        sel = which;
        @(posedge clk); #1;
        valor = v; sinal = s; set_start(which, 1'b1);
        @(posedge clk); #1;
        if (hold) valor = 16'd1;
        else      set_start(which, 1'b0);
        lat = 0; busyc = 0; dones = 0; mid = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 2) mid = bcd_s;
            if (busy_s) busyc++;
            if (done_s) begin
                dones++;
                if (lat == 0) lat = k;
                set_start(which, 1'b0);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        valor = '0; sinal = 1'b0;
        #12;
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_done", 64'(done_a), 64'd0);
        chk("rst_bcd",  64'(bcd_a),  64'd0);
        chk("rst_sign", 64'(sgn_a),  64'd0);
        chk("rst_ovf",  64'(ovf_a),  64'd0);
`ifdef CONVERSOR_SETE_SEG_EN
        chk("rst_seg",  64'(seg_a),  64'd0);
`endif
        @(posedge clk); #1 rst_n = 1'b1;

        conv(0, 16'd255, 1'b0, 1'b0);
        chk("a255_lat",   64'(lat),   64'd9);
        chk("a255_busy",  64'(busyc), 64'd9);
        chk("a255_dones", 64'(dones), 64'd1);
        chk("a255_bcd",   64'(bcd_a), 64'h255);
        chk("a255_ovf",   64'(ovf_a), 64'd0);
        chk("a255_sign",  64'(sgn_a), 64'd0);

        conv(0, 16'd0, 1'b1, 1'b0);
        chk("a0_hold",  64'(mid),   64'h255);
        chk("a0_bcd",   64'(bcd_a), 64'h000);
        chk("a0_sign",  64'(sgn_a), 64'd0);

        conv(0, 16'd5, 1'b0, 1'b0);
        chk("a5_bcd", 64'(bcd_a), 64'h005);
`ifdef CONVERSOR_SETE_SEG_EN
        chk("a5_seg0",  64'(seg_a[6:0]),  64'b1101101);
        chk("a5_blank", 64'(seg_a[20:7]), 64'd0);
`endif

        conv(0, 16'd100, 1'b0, 1'b0);
        chk("a100_bcd", 64'(bcd_a), 64'h100);
`ifdef CONVERSOR_SETE_SEG_EN
        chk("a100_seg", 64'(seg_a), 64'({7'b0000110, 7'b0111111, 7'b0111111}));
`endif

        conv(0, 16'd7, 1'b1, 1'b0);
        chk("a7_hold", 64'(mid),   64'h100);
        chk("a7_bcd",  64'(bcd_a), 64'h007);
        chk("a7_sign", 64'(sgn_a), 64'd1);

        conv(1, 16'd200, 1'b0, 1'b0);
        chk("b200_lat", 64'(lat),   64'd9);
        chk("b200_ovf", 64'(ovf_b), 64'd1);
        chk("b200_bcd", 64'(bcd_b), 64'h00);
        conv(1, 16'd99, 1'b0, 1'b0);
        chk("b99_ovf",  64'(ovf_b), 64'd0);
        chk("b99_bcd",  64'(bcd_b), 64'h99);
        conv(1, 16'd100, 1'b1, 1'b0);
        chk("b100_ovf", 64'(ovf_b), 64'd1);
        chk("b100_bcd", 64'(bcd_b), 64'h00);
        chk("b100_sign", 64'(sgn_b), 64'd1);

        conv(2, 16'd65535, 1'b0, 1'b1);
        chk("c_lat",   64'(lat),   64'd17);
        chk("c_busy",  64'(busyc), 64'd17);
        chk("c_dones", 64'(dones), 64'd1);
        chk("c_bcd",   64'(bcd_c), 64'h65535);
        chk("c_ovf",   64'(ovf_c), 64'd0);

        // Abort mid-conversion: outputs clear without waiting for an edge.
        sel = 0;
        @(posedge clk); #1;
        valor = 16'd128; sinal = 1'b0; start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("ab_busy", 64'(busy_a), 64'd0);
        chk("ab_done", 64'(done_a), 64'd0);
        chk("ab_bcd",  64'(bcd_a),  64'd0);
        chk("ab_sign", 64'(sgn_a),  64'd0);
        chk("ab_bcdc", 64'(bcd_c),  64'd0);
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done_a) dones++;
        end
        chk("ab_nodone", 64'(dones), 64'd0);

        conv(0, 16'd42, 1'b0, 1'b0);
        chk("a42_bcd", 64'(bcd_a), 64'h042);
        chk("a42_lat", 64'(lat),   64'd9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
